// File: rtl/icache_dm_pkg.sv
// Shared definitions for the direct-mapped instruction cache: default geometry,
// derived address-field widths, FSM encoding and the NOP instruction.
package icache_dm_pkg;

  localparam int LINES_DEF  = 16;
  localparam int WORDS_DEF  = 4;
  localparam int ADDR_W_DEF = 32;

  localparam int WORD_BITS  = $clog2(WORDS_DEF);
  localparam int INDEX_BITS = $clog2(LINES_DEF);
  localparam int TAG_BITS   = ADDR_W_DEF - INDEX_BITS - WORD_BITS - 2;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    REFILL    = 2'd1,
    FILL_DONE = 2'd2
  } state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0;

endpackage

// File: rtl/icache_tag_array.sv
// Valid + tag storage for the direct-mapped cache: combinational hit compare,
// single-line invalidate, synchronous tag write, bulk invalidate.
module icache_tag_array #(
  parameter int LINES      = 16,
  parameter int TAG_BITS   = 24,
  parameter int INDEX_BITS = $clog2(LINES)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  flush,
  input  logic [INDEX_BITS-1:0] rd_index,
  input  logic [TAG_BITS-1:0]   rd_tag,
  output logic                  hit,
  input  logic                  inval,
  input  logic [INDEX_BITS-1:0] inval_index,
  input  logic                  wr,
  input  logic [INDEX_BITS-1:0] wr_index,
  input  logic [TAG_BITS-1:0]   wr_tag
);

  logic [LINES-1:0]    valid;
  logic [TAG_BITS-1:0] tags [LINES];

  assign hit = valid[rd_index] && (tags[rd_index] == rd_tag);

  // Bulk invalidate wins over a same-edge fill so an aborted line never validates.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      valid <= '0;
    end else begin
      if (inval) valid[inval_index] <= 1'b0;
      if (wr)    valid[wr_index]    <= 1'b1;
    end
  end

  // NOTE: the tag RAM has no reset; a stale tag is harmless while its valid bit is 0.
  always_ff @(posedge clock) begin
    if (wr) tags[wr_index] <= wr_tag;
  end

endmodule

// File: rtl/icache_dm.sv
// Direct-mapped read-only instruction cache: zero-cycle hits, whole-line refill
// over a one-outstanding req/ready word interface on a miss.
module icache_dm
  import icache_dm_pkg::*;
#(
  parameter int LINES          = LINES_DEF,
  parameter int WORDS_PER_LINE = WORDS_DEF,
  parameter int ADDR_W         = ADDR_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              flush,
  output logic [31:0]       cpu_instr,
  output logic              stall,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ready,
  input  logic [31:0]       mem_rdata,
  output logic [15:0]       miss_count
);

  localparam int WB = $clog2(WORDS_PER_LINE);
  localparam int IB = $clog2(LINES);
  localparam int TB = ADDR_W - IB - WB - 2;
  localparam logic [WB-1:0] LAST_BEAT = WB'(WORDS_PER_LINE - 1);

  logic [WB-1:0] word;
  logic [IB-1:0] index;
  logic [TB-1:0] tag;
  logic          unused_offset;

  assign word          = cpu_addr[WB+1:2];
  assign index         = cpu_addr[WB+IB+1:WB+2];
  assign tag           = cpu_addr[ADDR_W-1:WB+IB+2];
  assign unused_offset = ^cpu_addr[1:0];

  state_t        state, state_next;
  logic [TB-1:0] line_tag;
  logic [IB-1:0] line_index;
  logic [WB-1:0] beat;
  logic          hit, start_miss, beat_done, fill_last;
  logic [31:0]   data [LINES*WORDS_PER_LINE];

  assign beat_done = (state == REFILL) && mem_ready;
  assign fill_last = beat_done && (beat == LAST_BEAT) && !flush;
  assign mem_addr  = {line_tag, line_index, beat, 2'b00};

  icache_tag_array #(
    .LINES    (LINES),
    .TAG_BITS (TB)
  ) u_tags (
    .clock       (clock),
    .reset       (reset),
    .flush       (flush),
    .rd_index    (index),
    .rd_tag      (tag),
    .hit         (hit),
    .inval       (start_miss),
    .inval_index (index),
    .wr          (fill_last),
    .wr_index    (line_index),
    .wr_tag      (line_tag)
  );

  // NOTE: every output of this block gets a default first, so no latches are inferred.
  always_comb begin
    state_next = state;
    stall      = 1'b0;
    mem_req    = 1'b0;
    cpu_instr  = NOP_INSTR;
    start_miss = 1'b0;
    unique case (state)
      IDLE: begin
        if (cpu_req) begin
          if (hit) begin
            cpu_instr = data[{index, word}];
          end else begin
            stall = 1'b1;
            // A flush in the miss cycle defers the refill; the next lookup misses again.
            if (!flush) begin
              start_miss = 1'b1;
              state_next = REFILL;
            end
          end
        end
      end
      REFILL: begin
        stall   = 1'b1;
        mem_req = 1'b1;
        if (flush)                                state_next = IDLE;
        else if (beat_done && beat == LAST_BEAT) state_next = FILL_DONE;
      end
      FILL_DONE: begin
        stall      = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      beat       <= '0;
      miss_count <= '0;
    end else begin
      state <= state_next;
      if (start_miss) begin
        beat <= '0;
        if (miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;
      end else if (beat_done) begin
        beat <= beat + WB'(1);
      end
    end
  end

  // Line address is only meaningful while a refill is in flight.
  always_ff @(posedge clock) begin
    if (start_miss) begin
      line_tag   <= tag;
      line_index <= index;
    end
  end

  always_ff @(posedge clock) begin
    if (beat_done) data[{line_index, beat}] <= mem_rdata;
  end

endmodule
